// File: rtl/systolic_pkg.sv
// Types and default sizing shared by the weight loader, the PE and the array wrappers.
package systolic_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_N      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/weight_tile_buffer.sv
// N x N weight tile register file: one row-write port, one combinational row-read port.
// A read of the row being written in the same cycle returns the incoming data.
module weight_tile_buffer #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int AW     = $clog2(N)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [N*DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [N*DATA_W-1:0] o_rdata
);

  logic [N*DATA_W-1:0] r_mem [N];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Write-through lets the loader replay the last row in the same edge it is captured.
  always_comb begin
    if (i_we && (i_waddr == i_raddr)) begin
      o_rdata = i_wdata;
    end else begin
      o_rdata = r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/systolic_weight_loader.sv
// Buffers an N x N weight tile from a row stream and replays it into the systolic array edge,
// upward through the bottom row (normal) or rightward through the left column (transpose).
module systolic_weight_loader
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N      = DEFAULT_N
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_transpose,
  input  logic [N*DATA_W-1:0] i_w_row_data,
  input  logic                i_w_row_valid,
  output logic                o_w_row_ready,
  output logic                o_load_w,
  output logic                o_transpose_en,
  output logic [N*DATA_W-1:0] o_w_col_out,
  output logic [N*DATA_W-1:0] o_w_row_out,
  output logic                o_busy,
  output logic                o_done,
  output logic [1:0]          o_state
);

  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  // Row handshake: a row transfers on every rising edge where i_w_row_valid and
  // o_w_row_ready are both high; ready depends only on state, never on valid.

  loader_state_t       r_state;
  logic [CW-1:0]       r_row_cnt;
  logic [CW-1:0]       r_beat_cnt;
  logic                r_transpose_en;
  logic                r_load_w;
  logic                r_done;
  logic                r_busy;
  logic [N*DATA_W-1:0] r_col_out;
  logic [N*DATA_W-1:0] r_row_out;

  loader_state_t       w_state_nxt;
  logic [CW-1:0]       w_row_cnt_nxt;
  logic [CW-1:0]       w_beat_cnt_nxt;
  logic                w_tr_nxt;
  logic                w_we;
  logic                w_shift_nxt;
  logic [CW-1:0]       w_rd_idx;
  logic [N*DATA_W-1:0] w_rd_data;

  weight_tile_buffer #(
    .DATA_W (DATA_W),
    .N      (N),
    .AW     (CW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_waddr (r_row_cnt),
    .i_wdata (i_w_row_data),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_row_cnt_nxt  = r_row_cnt;
    w_beat_cnt_nxt = r_beat_cnt;
    w_tr_nxt       = r_transpose_en;
    w_we           = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt    = FILL;
          w_tr_nxt       = i_transpose;
          w_row_cnt_nxt  = '0;
          w_beat_cnt_nxt = '0;
        end
      end
      FILL: begin
        if (i_w_row_valid) begin
          w_we = 1'b1;
          if (r_row_cnt == LAST) begin
            w_state_nxt    = SHIFT;
            w_beat_cnt_nxt = '0;
          end else begin
            w_row_cnt_nxt = r_row_cnt + CW'(1);
          end
        end
      end
      SHIFT: begin
        if (r_beat_cnt == LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_beat_cnt_nxt = r_beat_cnt + CW'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so each beat's data lines up with load_w.
  // Transpose replays rows last-first so beat k settles in array column N-1-k.
  always_comb begin
    w_shift_nxt = (w_state_nxt == SHIFT);
    w_rd_idx    = w_tr_nxt ? (LAST - w_beat_cnt_nxt) : w_beat_cnt_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_row_cnt      <= '0;
      r_beat_cnt     <= '0;
      r_transpose_en <= 1'b0;
      r_load_w       <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_col_out      <= '0;
      r_row_out      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_row_cnt      <= w_row_cnt_nxt;
      r_beat_cnt     <= w_beat_cnt_nxt;
      r_transpose_en <= w_tr_nxt;
      r_load_w       <= w_shift_nxt;
      r_done         <= (w_state_nxt == DONE);
      r_busy         <= (w_state_nxt != IDLE);
      r_col_out      <= (w_shift_nxt && !w_tr_nxt) ? w_rd_data : '0;
      r_row_out      <= (w_shift_nxt &&  w_tr_nxt) ? w_rd_data : '0;
    end
  end

  assign o_w_row_ready  = (r_state == FILL);
  assign o_load_w       = r_load_w;
  assign o_transpose_en = r_transpose_en;
  assign o_w_col_out    = r_col_out;
  assign o_w_row_out    = r_row_out;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_state        = r_state;

endmodule

// File: doc/systolic_weight_loader.md
# systolic_weight_loader

- Drives the weight-load side of the systolic array: buffers an N×N weight tile from an upstream valid/ready row stream, then replays it into the array edge.
- In normal mode it shifts rows upward through the bottom-row `w_in_down` inputs; in transpose mode it shifts columns rightward through the left-column `w_in_left` inputs.
- It asserts `load_w` for exactly N cycles, which also freezes the PE MAC pipeline during the load.
- Sits between the weight SRAM reader and the array.

## Interface
- `DATA_W`, 8, weight element width.
- `N`, 4, array dimension; the array is square, so ROWS = COLS = N, N ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to load a tile; accepted only in IDLE.
- `transpose` input 1: mode select, sampled when `start` is accepted.
- `w_row_data` input N*DATA_W: one weight row; element c occupies bits [c*DATA_W +: DATA_W].
- `w_row_valid` input 1: upstream row valid.
- `w_row_ready` output 1: loader can accept a row.
- `load_w` output 1: array weight-load enable.
- `transpose_en` output 1: array transpose select.
- `w_col_out` output N*DATA_W: drives the bottom-row `w_in_down`; lane c goes to column c.
- `w_row_out` output N*DATA_W: drives the left-column `w_in_left`; lane r goes to row r.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last shift cycle.

## Operation
- FSM states: IDLE, FILL, SHIFT, DONE.
- IDLE → FILL: `start`=1. On this transition, latch `transpose`, clear the row counter, clear the beat counter.
- `start` outside IDLE: ignored, with no side effects.
- FILL:
  - `w_row_ready`=1.
  - Each cycle with `w_row_valid`&&`w_row_ready` writes `w_row_data` into buffer row `row_cnt`, then increments `row_cnt`.
  - After the beat with `row_cnt`==N-1, go to SHIFT.
  - No timeout; valid gaps simply stall FILL.
- SHIFT:
  - `load_w`=1 for exactly N consecutive cycles, k = 0..N-1.
  - Normal mode (`transpose_en`=0):
    - `w_col_out` = buffer row k.
    - `w_row_out` = 0.
    - Row 0 is sent first and ends in the top array row, so PE(r,c) = W[r][c].
  - Transpose mode (`transpose_en`=1):
    - `w_row_out` = buffer row N-1-k; lane r = W[N-1-k][r].
    - `w_col_out` = 0.
    - The beat sent at k ends in array column N-1-k, so PE(r,c) = W[c][r].
  - After k = N-1, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `transpose_en`:
  - Updated only on `start` acceptance.
  - Held constant from the first FILL cycle until the next accepted `start`.
  - Never changes while `load_w`=1. This is required, because array weight forwarding depends on it.
- The buffer holds its contents after DONE; a new FILL overwrites it row by row.
- The inactive edge bus is always driven to zero, never to stale data.
- Counters are $clog2(N) bits wide and compare against N-1. They never wrap, because the FSM exits first.

## Timing
- All outputs are registered; none are combinational from inputs, except that `w_row_ready` is decoded directly from state.
- Reset values: `load_w`=0, `transpose_en`=0, `w_col_out`=0, `w_row_out`=0, `w_row_ready`=0, `busy`=0, `done`=0. State = IDLE, counters = 0, buffer = 0.
- Back-to-back schedule (`start` at cycle t, `w_row_valid` constantly high):
  - FILL accepts rows in cycles t+1 … t+N.
  - `load_w`=1 in cycles t+N+1 … t+2N, with beat k's data valid in the same cycle that `load_w` is high.
  - `done` = 1 in cycle t+2N+1.
  - IDLE in cycle t+2N+2; a new `start` is accepted there.
- Minimum tile period: 2N+2 cycles.
- A `start` that arrives together with `done` is ignored.
- `rst` asserted mid-FILL or mid-SHIFT: all outputs go to zero asynchronously and the FSM enters IDLE. Any partial tile in the array is invalid; the controller must reload it.
- `rst` deasserting: synchronized externally; the block leaves IDLE only on `start`.

## Structure
- Shared package `systolic_pkg`:
  - `loader_state_t` enum {IDLE, FILL, SHIFT, DONE}.
  - Default `DATA_W`/`N` localparams, shared with the PE and array wrappers.
- Sub-module `weight_tile_buffer`: N×N×DATA_W register file with one row-write port and one row-read port. The read index is a combinational mux, registered at the loader outputs.
- Top level: FSM, `row_cnt`, `beat_cnt`, `transpose_en` latch, output registers.

## Test plan
- Normal load, N=4, W[r][c] = 16r+c:
  - Required: `load_w` high for exactly 4 cycles.
  - Required: `w_col_out` beats are rows 0,1,2,3; `w_row_out`=0.
  - Array model ends with PE(2,1)=0x21 and `done` pulses once.
- Transpose load, same W:
  - Required: `w_row_out` beats are rows 3,2,1,0; `w_col_out`=0; `transpose_en`=1 through SHIFT.
  - Array model ends with PE(2,1)=0x12.
- Valid gaps: `w_row_valid` toggles 1,0,0,1,1,0,1.
  - Required: exactly 4 rows are captured and SHIFT starts the cycle after the 4th accept.
  - Required: `w_row_ready` is never high outside FILL.
- Ignored start: `start` pulsed during FILL, SHIFT and DONE, and `transpose` toggled.
  - Required: no state or mode change; next tile starts only from IDLE, exactly 2N+2 cycles after the first `start`.
- Reset mid-SHIFT: `rst` asserted at beat k=2.
  - Required: `load_w`, `busy` and both buses are 0 in the same cycle; no `done`.
  - Required: after release, a fresh tile loads correctly.
